// File: rtl/mem_stream_programmer_if.sv
// Bus bundle for mem_stream_programmer: MCU byte link, CPU-side memory
// strobes coming in, memory-side copies going out, and session status.
interface mem_stream_programmer_if #(
  parameter int ADDR_W = 32
);
  logic [9:0]        progData;
  logic              cpu_RST;
  logic              memWrite;
  logic              memRead1;
  logic              memRead2;
  logic [ADDR_W-1:0] addr2;
  logic [31:0]       din2;
  logic [1:0]        size;
  logic              sign;

  logic              prog_RST;
  logic              prog_memWrite;
  logic              prog_memRead1;
  logic              prog_memRead2;
  logic [ADDR_W-1:0] prog_addr2;
  logic [31:0]       prog_din2;
  logic [1:0]        prog_size;
  logic              prog_sign;
  logic              prog_done;
  logic [ADDR_W-1:0] word_count;
  logic [7:0]        checksum;

  // The programmer block itself
  modport slave (
    input  progData, cpu_RST, memWrite, memRead1, memRead2, addr2, din2, size, sign,
    output prog_RST, prog_memWrite, prog_memRead1, prog_memRead2, prog_addr2,
           prog_din2, prog_size, prog_sign, prog_done, word_count, checksum
  );

  // The environment driving the MCU link and CPU strobes
  modport master (
    output progData, cpu_RST, memWrite, memRead1, memRead2, addr2, din2, size, sign,
    input  prog_RST, prog_memWrite, prog_memRead1, prog_memRead2, prog_addr2,
           prog_din2, prog_size, prog_sign, prog_done, word_count, checksum
  );
endinterface

// File: rtl/mem_stream_programmer.sv
// Streams bytes from an asynchronous MCU link into memory words while holding
// the CPU in reset; transparent to the CPU bus when no session is active.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pass-through, waiting for synced CS high
// COLLECT  | packing accepted bytes into the word buffer
// WRITE    | one-cycle write of a full word, then advance address
// FLUSH    | one-cycle write of a partial word after CS dropped
// FINISH   | prog_done pulse, address reload, back to IDLE
module mem_stream_programmer #(
  parameter int                ADDR_W         = 32,
  parameter int                BYTES_PER_WORD = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                SYNC_STAGES    = 2
) (
  input logic CLK,
  input logic RST,
  mem_stream_programmer_if.slave bus
);

  localparam int                LANE_W    = 8 * BYTES_PER_WORD;
  localparam int                IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [1:0]        SIZE_CODE = (BYTES_PER_WORD == 4) ? 2'd2 :
                                            (BYTES_PER_WORD == 2) ? 2'd1 : 2'd0;

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FLUSH, FINISH} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] ena_sync;
  logic                ena_prev;
  logic                cs_s;
  logic                ena_s;
  logic                accept;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   word_count_q;
  logic [7:0]          checksum_q;
  logic [7:0]          pend_byte;
  logic [7:0]          byte_in;
  logic [IDX_W-1:0]    byte_idx;
  logic [LANE_W-1:0]   word_buf;
  logic                pending;
  logic                done_q;
  logic [31:0]         din_ext;

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign ena_s   = ena_sync[SYNC_STAGES-1];
  assign accept  = ena_s & ~ena_prev;
  // A byte held over from a WRITE cycle takes priority; otherwise the link
  // data is stable while ENA is high, so it is sampled directly.
  assign byte_in = pending ? pend_byte : bus.progData[7:0];

  assign bus.prog_done  = done_q;
  assign bus.word_count = word_count_q;
  assign bus.checksum   = checksum_q;

  // Bring CS and ENA into the CLK domain and keep one stage of ENA history for edge detect
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_sync  <= '0;
      ena_sync <= '0;
      ena_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.progData[8]};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], bus.progData[9]};
      ena_prev <= ena_s;
    end
  end

  // Zero-extend the word buffer onto the 32-bit write data bus
  always_comb begin
    din_ext = '0;
    din_ext[LANE_W-1:0] = word_buf;
  end

  // Memory-side mux: transparent in IDLE (including while RST holds IDLE), owned otherwise
  always_comb begin
    if (state == IDLE) begin
      bus.prog_RST      = bus.cpu_RST;
      bus.prog_memWrite = bus.memWrite;
      bus.prog_memRead1 = bus.memRead1;
      bus.prog_memRead2 = bus.memRead2;
      bus.prog_addr2    = bus.addr2;
      bus.prog_din2     = bus.din2;
      bus.prog_size     = bus.size;
      bus.prog_sign     = bus.sign;
    end else begin
      bus.prog_RST      = 1'b1;
      bus.prog_memWrite = (state == WRITE) || (state == FLUSH);
      bus.prog_memRead1 = 1'b0;
      bus.prog_memRead2 = 1'b0;
      bus.prog_addr2    = addr_q;
      bus.prog_din2     = din_ext;
      bus.prog_size     = SIZE_CODE;
      bus.prog_sign     = 1'b0;
    end
  end

  // Session FSM: byte packing, word writes, partial flush and done pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      addr_q       <= BASE_ADDR;
      word_count_q <= '0;
      checksum_q   <= '0;
      word_buf     <= '0;
      byte_idx     <= '0;
      pending      <= 1'b0;
      pend_byte    <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_s) begin
            word_count_q <= '0;
            checksum_q   <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            pending      <= 1'b0;
            state        <= COLLECT;
          end
        end
        COLLECT: begin
          if (!cs_s) begin
            // A byte arriving together with CS low belongs to no session.
            pending <= 1'b0;
            if (byte_idx != '0) begin
              state <= FLUSH;
            end else begin
              state  <= FINISH;
              done_q <= 1'b1;
            end
          end else if (accept || pending) begin
            pending <= 1'b0;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
              if (byte_idx == IDX_W'(i)) word_buf[8*i +: 8] <= byte_in;
            end
            checksum_q <= checksum_q + byte_in;
            if (byte_idx == LAST_IDX) state <= WRITE;
            else byte_idx <= byte_idx + IDX_ONE;
          end
        end
        WRITE: begin
          addr_q       <= addr_q + ADDR_STEP;
          word_count_q <= word_count_q + CNT_ONE;
          byte_idx     <= '0;
          word_buf     <= '0;
          if (accept) begin
            pending   <= 1'b1;
            pend_byte <= bus.progData[7:0];
          end
          state <= COLLECT;
        end
        FLUSH: begin
          addr_q       <= addr_q + ADDR_STEP;
          word_count_q <= word_count_q + CNT_ONE;
          byte_idx     <= '0;
          word_buf     <= '0;
          done_q       <= 1'b1;
          state        <= FINISH;
        end
        FINISH: begin
          addr_q <= BASE_ADDR;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parameter sanity: aligned base address, legal word size, enough sync stages
  a_params_legal: assert property (@(posedge CLK)
    ((BASE_ADDR & ADDR_W'(BYTES_PER_WORD - 1)) == '0) &&
    (BYTES_PER_WORD == 1 || BYTES_PER_WORD == 2 || BYTES_PER_WORD == 4) &&
    (SYNC_STAGES >= 2))
    else $error("mem_stream_programmer: illegal parameter set");

endmodule

// File: tb/tb_mem_stream_programmer.sv
// Directed self-checking bench for mem_stream_programmer: a 4-byte-word
// instance with 32-bit addresses and a 1-byte-word instance with 4-bit addresses.
module tb_mem_stream_programmer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  prog_data;
  logic        cpu_rst, cpu_wr, cpu_rd1, cpu_rd2, cpu_sign;
  logic [31:0] cpu_addr, cpu_din;
  logic [1:0]  cpu_size;

  mem_stream_programmer_if #(.ADDR_W(32)) bus4 ();
  mem_stream_programmer_if #(.ADDR_W(4))  bus1 ();

  assign bus4.progData = prog_data;
  assign bus4.cpu_RST  = cpu_rst;
  assign bus4.memWrite = cpu_wr;
  assign bus4.memRead1 = cpu_rd1;
  assign bus4.memRead2 = cpu_rd2;
  assign bus4.addr2    = cpu_addr;
  assign bus4.din2     = cpu_din;
  assign bus4.size     = cpu_size;
  assign bus4.sign     = cpu_sign;

  assign bus1.progData = prog_data;
  assign bus1.cpu_RST  = cpu_rst;
  assign bus1.memWrite = cpu_wr;
  assign bus1.memRead1 = cpu_rd1;
  assign bus1.memRead2 = cpu_rd2;
  assign bus1.addr2    = cpu_addr[3:0];
  assign bus1.din2     = cpu_din;
  assign bus1.size     = cpu_size;
  assign bus1.sign     = cpu_sign;

  mem_stream_programmer #(.ADDR_W(32), .BYTES_PER_WORD(4), .BASE_ADDR(32'h0), .SYNC_STAGES(2))
    dut4 (.CLK(clk), .RST(rst), .bus(bus4));

  mem_stream_programmer #(.ADDR_W(4), .BYTES_PER_WORD(1), .BASE_ADDR(4'h0), .SYNC_STAGES(2))
    dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  // Write monitors
  logic        mon_en = 1'b0;
  logic [31:0] q4_addr[$];
  logic [31:0] q4_data[$];
  logic [1:0]  q4_size[$];
  logic        q4_ok[$];
  logic [3:0]  q1_addr[$];
  logic [31:0] q1_data[$];
  logic [1:0]  q1_size[$];
  int          done4 = 0;
  int          done1 = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus4.prog_memWrite) begin
        q4_addr.push_back(bus4.prog_addr2);
        q4_data.push_back(bus4.prog_din2);
        q4_size.push_back(bus4.prog_size);
        q4_ok.push_back(bus4.prog_RST & ~bus4.prog_memRead1 & ~bus4.prog_memRead2 & ~bus4.prog_sign);
      end
      if (bus1.prog_memWrite) begin
        q1_addr.push_back(bus1.prog_addr2);
        q1_data.push_back(bus1.prog_din2);
        q1_size.push_back(bus1.prog_size);
      end
      if (bus4.prog_done) done4++;
      if (bus1.prog_done) done1++;
    end
  end

  task automatic session_cpu_inputs();
    cpu_rst  = 1'b0;
    cpu_wr   = 1'b0;
    cpu_rd1  = 1'b1;
    cpu_rd2  = 1'b1;
    cpu_sign = 1'b1;
    cpu_size = 2'd3;
    cpu_addr = 32'hFFFF_FFF0;
    cpu_din  = 32'hCAFE_F00D;
  endtask

  task automatic start_session();
    q4_addr.delete(); q4_data.delete(); q4_size.delete(); q4_ok.delete();
    q1_addr.delete(); q1_data.delete(); q1_size.delete();
    done4  = 0;
    done1  = 0;
    mon_en = 1'b1;
    @(posedge clk); #2;
    prog_data[8] = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    prog_data[7:0] = b;
    prog_data[9]   = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    prog_data[9] = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic end_session();
    @(posedge clk); #2;
    prog_data[8] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    prog_data = '0;
    cpu_rst   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_rd1   = 1'b1;
    cpu_rd2   = 1'b0;
    cpu_sign  = 1'b0;
    cpu_size  = 2'd1;
    cpu_addr  = 32'h0000_0040;
    cpu_din   = 32'h0000_1234;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus4.word_count, bus4.checksum, bus4.prog_done} !== 41'h0) begin
      n_bad++;
      $display("FAIL reset_status4: got wc=%h cs=%h done=%b expected all zero",
               bus4.word_count, bus4.checksum, bus4.prog_done);
    end
    n_cmp++;
    if ({bus1.word_count, bus1.checksum, bus1.prog_done} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_status1: got wc=%h cs=%h done=%b expected all zero",
               bus1.word_count, bus1.checksum, bus1.prog_done);
    end
    n_cmp++;
    if ({bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_size, bus4.prog_addr2} !==
        {1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0040}) begin
      n_bad++;
      $display("FAIL reset_passthru: got rst=%b wr=%b rd1=%b size=%0d addr=%h expected 1 0 1 1 00000040",
               bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_size, bus4.prog_addr2);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_passthrough();
    @(posedge clk); #2;
    cpu_rst  = 1'b0;
    cpu_wr   = 1'b1;
    cpu_rd1  = 1'b0;
    cpu_rd2  = 1'b1;
    cpu_sign = 1'b1;
    cpu_size = 2'd1;
    cpu_addr = 32'h0000_0100;
    cpu_din  = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
         bus4.prog_sign, bus4.prog_size} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL pass_ctrl_a: got %b%b%b%b%b size=%0d expected 01011 size=1",
               bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
               bus4.prog_sign, bus4.prog_size);
    end
    n_cmp++;
    if ({bus4.prog_addr2, bus4.prog_din2} !== {32'h0000_0100, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL pass_bus_a: got addr=%h din=%h expected 00000100 deadbeef",
               bus4.prog_addr2, bus4.prog_din2);
    end
    #3;
    cpu_rst  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_rd1  = 1'b1;
    cpu_rd2  = 1'b0;
    cpu_sign = 1'b0;
    cpu_size = 2'd2;
    cpu_addr = 32'h0000_0ABC;
    cpu_din  = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
         bus4.prog_sign, bus4.prog_size, bus4.prog_addr2, bus4.prog_din2} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0ABC, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL pass_b: got %b%b%b%b%b size=%0d addr=%h din=%h expected 10100 size=2 00000abc 12345678",
               bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
               bus4.prog_sign, bus4.prog_size, bus4.prog_addr2, bus4.prog_din2);
    end
    n_cmp++;
    if ({bus1.prog_addr2, bus1.prog_RST} !== {4'hC, 1'b1}) begin
      n_bad++;
      $display("FAIL pass_b1: got addr=%h rst=%b expected c 1", bus1.prog_addr2, bus1.prog_RST);
    end
  endtask

  task automatic test_full_words();
    session_cpu_inputs();
    start_session();
    send_byte(8'h11);
    @(negedge clk);
    n_cmp++;
    if ({bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
         bus4.prog_sign, bus4.prog_size, bus4.prog_addr2} !== {5'b10000, 2'd2, 32'h0}) begin
      n_bad++;
      $display("FAIL collect_ctrl: got %b%b%b%b%b size=%0d addr=%h expected 10000 size=2 00000000",
               bus4.prog_RST, bus4.prog_memWrite, bus4.prog_memRead1, bus4.prog_memRead2,
               bus4.prog_sign, bus4.prog_size, bus4.prog_addr2);
    end
    for (int i = 2; i <= 8; i++) send_byte(8'(8'h11 * i));
    end_session();
    n_cmp++;
    if (q4_addr.size() !== 2) begin
      n_bad++;
      $display("FAIL full_nwrites: got %0d expected 2", q4_addr.size());
    end else begin
      n_cmp++;
      if ({q4_addr[0], q4_data[0], q4_addr[1], q4_data[1]} !==
          {32'h0, 32'h4433_2211, 32'h4, 32'h8877_6655}) begin
        n_bad++;
        $display("FAIL full_writes: got (%h,%h) (%h,%h) expected (00000000,44332211) (00000004,88776655)",
                 q4_addr[0], q4_data[0], q4_addr[1], q4_data[1]);
      end
      n_cmp++;
      if ({q4_size[0], q4_size[1], q4_ok[0], q4_ok[1]} !== {2'd2, 2'd2, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL full_wr_ctrl: got size %0d %0d ctrl_ok %b %b expected 2 2 1 1",
                 q4_size[0], q4_size[1], q4_ok[0], q4_ok[1]);
      end
    end
    n_cmp++;
    if (done4 !== 1) begin
      n_bad++;
      $display("FAIL full_done: got %0d pulses expected 1", done4);
    end
    n_cmp++;
    if ({bus4.word_count, bus4.checksum} !== {32'd2, 8'h64}) begin
      n_bad++;
      $display("FAIL full_status: got wc=%0d cs=%h expected 2 64", bus4.word_count, bus4.checksum);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({bus4.word_count, bus4.checksum} !== {32'd2, 8'h64}) begin
      n_bad++;
      $display("FAIL idle_hold: got wc=%0d cs=%h expected 2 64", bus4.word_count, bus4.checksum);
    end
  endtask

  task automatic test_partial();
    session_cpu_inputs();
    start_session();
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h11 * i));
    end_session();
    n_cmp++;
    if (q4_addr.size() !== 2) begin
      n_bad++;
      $display("FAIL part_nwrites: got %0d expected 2", q4_addr.size());
    end else begin
      n_cmp++;
      if ({q4_addr[0], q4_data[0], q4_addr[1], q4_data[1], q4_size[1]} !==
          {32'h0, 32'h4433_2211, 32'h4, 32'h0000_0055, 2'd2}) begin
        n_bad++;
        $display("FAIL part_writes: got (%h,%h) (%h,%h) size=%0d expected (00000000,44332211) (00000004,00000055) size=2",
                 q4_addr[0], q4_data[0], q4_addr[1], q4_data[1], q4_size[1]);
      end
    end
    n_cmp++;
    if ({bus4.word_count, bus4.checksum, done4[7:0]} !== {32'd2, 8'hFF, 8'd1}) begin
      n_bad++;
      $display("FAIL part_status: got wc=%0d cs=%h done=%0d expected 2 ff 1",
               bus4.word_count, bus4.checksum, done4);
    end
  endtask

  task automatic test_reset_abort();
    session_cpu_inputs();
    start_session();
    send_byte(8'h5A);
    send_byte(8'h3C);
    @(posedge clk); #2;
    prog_data[8] = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus4.prog_RST, bus4.prog_memRead1, bus4.prog_sign} !== 3'b011) begin
      n_bad++;
      $display("FAIL abort_passthru: got rst=%b rd1=%b sign=%b expected 0 1 1",
               bus4.prog_RST, bus4.prog_memRead1, bus4.prog_sign);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({q4_addr.size(), done4, bus4.word_count, bus4.checksum} !== {32'd0, 32'd0, 32'd0, 8'h00}) begin
      n_bad++;
      $display("FAIL abort_nowrite: got writes=%0d done=%0d wc=%0d cs=%h expected 0 0 0 00",
               q4_addr.size(), done4, bus4.word_count, bus4.checksum);
    end
    start_session();
    for (int i = 1; i <= 4; i++) send_byte(8'(8'hA0 + i));
    end_session();
    n_cmp++;
    if (q4_addr.size() !== 1) begin
      n_bad++;
      $display("FAIL after_abort_nwrites: got %0d expected 1", q4_addr.size());
    end else begin
      n_cmp++;
      if ({q4_addr[0], q4_data[0]} !== {32'h0, 32'hA4A3_A2A1}) begin
        n_bad++;
        $display("FAIL after_abort_write: got (%h,%h) expected (00000000,a4a3a2a1)", q4_addr[0], q4_data[0]);
      end
    end
    n_cmp++;
    if ({bus4.word_count, bus4.checksum} !== {32'd1, 8'h8A}) begin
      n_bad++;
      $display("FAIL after_abort_status: got wc=%0d cs=%h expected 1 8a", bus4.word_count, bus4.checksum);
    end
  endtask

  task automatic test_discard();
    session_cpu_inputs();
    start_session();
    send_byte(8'h01);
    send_byte(8'h02);
    @(posedge clk); #2;
    prog_data = {1'b1, 1'b0, 8'h99};
    repeat (20) @(posedge clk);
    #2;
    prog_data[9] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    n_cmp++;
    if (q4_addr.size() !== 1) begin
      n_bad++;
      $display("FAIL discard_nwrites: got %0d expected 1", q4_addr.size());
    end else begin
      n_cmp++;
      if ({q4_addr[0], q4_data[0]} !== {32'h0, 32'h0000_0201}) begin
        n_bad++;
        $display("FAIL discard_write: got (%h,%h) expected (00000000,00000201)", q4_addr[0], q4_data[0]);
      end
    end
    n_cmp++;
    if ({bus4.word_count, bus4.checksum, done4[7:0]} !== {32'd1, 8'h03, 8'd1}) begin
      n_bad++;
      $display("FAIL discard_status: got wc=%0d cs=%h done=%0d expected 1 03 1",
               bus4.word_count, bus4.checksum, done4);
    end
  endtask

  task automatic test_byte_words();
    session_cpu_inputs();
    start_session();
    for (int i = 1; i <= 17; i++) send_byte(8'(i));
    end_session();
    n_cmp++;
    if (q1_addr.size() !== 17) begin
      n_bad++;
      $display("FAIL bpw1_nwrites: got %0d expected 17", q1_addr.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++;
        if ({q1_addr[i], q1_data[i], q1_size[i]} !== {4'(i), 32'(i + 1), 2'd0}) begin
          n_bad++;
          $display("FAIL bpw1_write%0d: got (%h,%h) size=%0d expected (%h,%h) size=0",
                   i, q1_addr[i], q1_data[i], q1_size[i], 4'(i), 32'(i + 1));
        end
      end
    end
    n_cmp++;
    if ({bus1.word_count, bus1.checksum, done1[7:0]} !== {4'd1, 8'h99, 8'd1}) begin
      n_bad++;
      $display("FAIL bpw1_status: got wc=%0d cs=%h done=%0d expected 1 99 1",
               bus1.word_count, bus1.checksum, done1);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full_words();
    test_partial();
    test_reset_abort();
    test_discard();
    test_byte_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stream_programmer.md
MEM_STREAM_PROGRAMMER -- requirements
Module: mem_stream_programmer

Interface
REQ-001 Parameter ADDR_W, 32, width of the memory address and word_count.
REQ-002 Parameter BYTES_PER_WORD, 4, bytes packed per memory write; legal values are 1, 2 and 4.
REQ-003 Parameter BASE_ADDR, 0, first write address of each session; it SHALL be aligned to BYTES_PER_WORD, checked by a simulation assertion.
REQ-004 Parameter SYNC_STAGES, 2, synchronizer depth for CS and ENA; minimum 2.
REQ-005 CLK  in  1  the single clock; one clock; reset is asynchronous and active-high.
REQ-006 RST  in  1  block reset, asynchronous, active-high.
REQ-007 progData  in  10  MCU link, asynchronous to CLK: [7:0] data byte, [8] CS, [9] ENA.
REQ-008 cpu_RST  in  1  CPU reset, passed through when idle.
REQ-009 memWrite  in  1  CPU write strobe, passed through.
REQ-010 memRead1  in  1  CPU fetch strobe, passed through.
REQ-011 memRead2  in  1  CPU data-read strobe, passed through.
REQ-012 addr2  in  ADDR_W  CPU data address, passed through.
REQ-013 din2  in  32  CPU write data, passed through.
REQ-014 size  in  2  CPU access size, passed through.
REQ-015 sign  in  1  CPU sign-extend flag, passed through.
REQ-016 prog_RST, prog_memWrite, prog_memRead1, prog_memRead2, prog_addr2 [ADDR_W], prog_din2 [32], prog_size [2], prog_sign  out  memory/CPU-side copies of the eight inputs above (one port each).
REQ-017 prog_done  out  1  one-cycle pulse marking session end.
REQ-018 word_count  out  ADDR_W  number of memory writes in the current or last session.
REQ-019 checksum  out  8  sum modulo 256 of all accepted bytes in the current or last session.

Function
REQ-020 CS and ENA SHALL pass through SYNC_STAGES flops; a rising edge of synced ENA is an "accept"; the byte is sampled from progData[7:0] on the accept cycle.
REQ-021 MCU timing contract: ENA high and low phases each last at least SYNC_STAGES+2 CLK cycles, and data is stable while ENA is high.
REQ-022 States: IDLE, COLLECT, WRITE, FLUSH, FINISH.
REQ-023 IDLE: every prog_* output equals its input combinationally; synced CS=1 -> COLLECT, clearing word_count, checksum, byte index and word buffer.
REQ-024 In every non-IDLE state, prog_RST=1, prog_memRead1=0, prog_memRead2=0, prog_sign=0, prog_size=log2(BYTES_PER_WORD), and prog_addr2=internal address.
REQ-025 prog_memWrite SHALL be 1 only in WRITE and FLUSH, for exactly one cycle per write.
REQ-026 COLLECT, on accept: place the byte at lane byte_idx (little-endian, lane 0 = bits [7:0]) and add it to checksum; if byte_idx=BYTES_PER_WORD-1 -> WRITE, else byte_idx+1.
REQ-027 WRITE: prog_din2 = word buffer zero-extended to 32 bits; then address += BYTES_PER_WORD (wraps mod 2^ADDR_W), word_count+1, byte_idx=0, buffer cleared -> COLLECT.
REQ-028 An accept arising during WRITE SHALL be held pending and consumed in the first COLLECT cycle; no byte is lost.
REQ-029 COLLECT with synced CS=0: byte_idx≠0 -> FLUSH (partial word written with unfilled lanes zero, full size, word_count+1); byte_idx=0 -> FINISH.
REQ-030 An accept in the same cycle as CS=0 SHALL be discarded: no lane written and no checksum change.
REQ-031 FINISH: prog_done=1 and prog_RST=1 for one cycle, address reloads BASE_ADDR -> IDLE.
REQ-032 word_count and checksum SHALL hold their values in IDLE until the next session starts.

Reset
REQ-033 RST asserted: state=IDLE, address=BASE_ADDR, word_count=0, checksum=0, buffer=0, byte_idx=0, synchronizers=0, pending=0, prog_done=0.
REQ-034 While RST is asserted, prog_* outputs SHALL follow pass-through; RST mid-session aborts with no further write.

Verification
REQ-035 Pass-through: CS=0, memWrite=1, addr2=0x100, din2=0xDEADBEEF -> prog_* equal the inputs in the same cycle, prog_RST=cpu_RST.
REQ-036 BYTES_PER_WORD=4, bytes 0x11..0x88, then CS low -> writes (0x0, 0x44332211) and (0x4, 0x88776655), size=2, prog_RST high throughout, one prog_done pulse, word_count=2, checksum=0x64.
REQ-037 Bytes 0x11..0x55, then CS low -> writes 0x44332211 at 0x0 and flush 0x00000055 at 0x4, word_count=2.
REQ-038 RST pulse after two accepted bytes -> no write; next session of 4 bytes writes at address 0x0.
REQ-039 BYTES_PER_WORD=1, ADDR_W=4, 17 bytes -> 17 single-byte writes with size=0, and the 17th write at address 0x0.
REQ-040 ENA synced rise in the same cycle as CS synced fall -> byte discarded; checksum and word_count unchanged.
